// File: rtl/scalar_wb_arbiter_pkg.sv
// Shared constants for the scalar write-back arbiter: register-file command codes,
// requester indices and a width helper for encoded grant indices.
package scalar_wb_arbiter_pkg;

    localparam logic [1:0] SCALAR_RF_NOP   = 2'b00;
    localparam logic [1:0] SCALAR_RF_WRITE = 2'b01;

    localparam int WB_REQ_ALU  = 0;
    localparam int WB_REQ_LOAD = 1;
    localparam int WB_REQ_VEC  = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scalar_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1, wrapping modulo
// NUM_REQ, and returns the first active request as one-hot plus encoded index.
module rr_arbiter
    import scalar_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Round-robin sharing of the scalar register-file write port, with a registered
// output stage and a 32-entry pending-write scoreboard for decode hazard checks.
module scalar_wb_arbiter
    import scalar_wb_arbiter_pkg::*;
#(
    parameter int SCALAR_REG_LEN = 64,
    parameter int NUM_REQ        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [5*NUM_REQ-1:0]          req_rd,
    input  logic [SCALAR_REG_LEN*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    input  logic [4:0]                    query_rs1,
    input  logic [4:0]                    query_rs2,
    input  logic [4:0]                    query_rd,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          rd_busy,
    output logic [1:0]                    rf_signal,
    output logic [4:0]                    wb_rd,
    output logic [SCALAR_REG_LEN-1:0]     wb_data,
    output logic                          write_back_enabled
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i].
    // req_ready is one-hot and may depend on req_valid; requesters hold rd/data
    // stable and must not make req_valid depend on req_ready.

    logic [NUM_REQ-1:0]        req_gated;
    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          grant_idx;
    logic [IDX_W-1:0]          last_grant;
    logic                      transfer;
    logic [4:0]                sel_rd;
    logic [SCALAR_REG_LEN-1:0] sel_data;
    logic [31:0]               busy;
    logic [31:0]               busy_next;

    assign req_gated = (rst && rdy_in) ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req       (req_gated),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd | req_rd[5*i +: 5];
                sel_data = sel_data | req_data[SCALAR_REG_LEN*i +: SCALAR_REG_LEN];
            end
        end
    end

    // Clear is applied first so a same-edge issue to the committing register wins.
    always_comb begin
        busy_next = busy;
        if (write_back_enabled) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy               <= '0;
            last_grant         <= IDX_W'(NUM_REQ - 1);
            write_back_enabled <= 1'b0;
            rf_signal          <= SCALAR_RF_NOP;
            wb_rd              <= '0;
            wb_data            <= '0;
        end else if (rdy_in) begin
            busy <= busy_next;
            if (transfer) begin
                last_grant <= grant_idx;
            end
            if (transfer && (sel_rd != 5'd0)) begin
                write_back_enabled <= 1'b1;
                rf_signal          <= SCALAR_RF_WRITE;
                wb_rd              <= sel_rd;
                wb_data            <= sel_data;
            end else begin
                write_back_enabled <= 1'b0;
                rf_signal          <= SCALAR_RF_NOP;
            end
        end
    end

    assign rs1_busy = busy[query_rs1];
    assign rs2_busy = busy[query_rs2];
    assign rd_busy  = busy[query_rd];

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter: inputs change on the falling edge, checks
// run 1ns later, so registered outputs reflect the preceding rising edge.
module tb_scalar_wb_arbiter;

    localparam int W = 64;
    localparam int N = 3;
    localparam logic [1:0] RF_NOP   = 2'b00;
    localparam logic [1:0] RF_WRITE = 2'b01;

    logic           clk;
    logic           rst;
    logic           rdy_in;
    logic [N-1:0]   req_valid;
    logic [5*N-1:0] req_rd;
    logic [W*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           issue_valid;
    logic [4:0]     issue_rd;
    logic [4:0]     query_rs1;
    logic [4:0]     query_rs2;
    logic [4:0]     query_rd;
    logic           rs1_busy;
    logic           rs2_busy;
    logic           rd_busy;
    logic [1:0]     rf_signal;
    logic [4:0]     wb_rd;
    logic [W-1:0]   wb_data;
    logic           write_back_enabled;

    int total;
    int bad;

    scalar_wb_arbiter #(
        .SCALAR_REG_LEN(W),
        .NUM_REQ       (N)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy_in            (rdy_in),
        .req_valid         (req_valid),
        .req_rd            (req_rd),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .issue_valid       (issue_valid),
        .issue_rd          (issue_rd),
        .query_rs1         (query_rs1),
        .query_rs2         (query_rs2),
        .query_rd          (query_rd),
        .rs1_busy          (rs1_busy),
        .rs2_busy          (rs2_busy),
        .rd_busy           (rd_busy),
        .rf_signal         (rf_signal),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .write_back_enabled(write_back_enabled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [1:0] sig,
                            input logic [4:0] rd, input logic [W-1:0] data);
        check({tag, "_en"}, W'(write_back_enabled), W'(en));
        check({tag, "_sig"}, W'(rf_signal), W'(sig));
        check({tag, "_rd"}, W'(wb_rd), W'(rd));
        check({tag, "_data"}, wb_data, data);
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [W-1:0] data);
        req_rd[5*i +: 5]   = rd;
        req_data[W*i +: W] = data;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        next();
        issue_valid = 1'b0;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; rdy_in = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        query_rs1 = '0; query_rs2 = '0; query_rd = '0;
        next();
        next();

        // Reset state
        check_wb("reset", 1'b0, RF_NOP, 5'd0, '0);
        query_rd = 5'd9;
        #1;
        check("reset_busy9", W'(rd_busy), W'(0));

        // Three requesters at once: grants 0,1,2 in order
        rst = 1'b1; rdy_in = 1'b1;
        set_req(0, 5'd5, 64'hA);
        set_req(1, 5'd6, 64'hB);
        set_req(2, 5'd7, 64'hC);
        req_valid = 3'b111;
        #1;
        check("rr_g0", W'(req_ready), W'(3'b001));
        next();
        check_wb("rr_w5", 1'b1, RF_WRITE, 5'd5, 64'hA);
        check("rr_g1", W'(req_ready), W'(3'b010));
        next();
        check_wb("rr_w6", 1'b1, RF_WRITE, 5'd6, 64'hB);
        check("rr_g2", W'(req_ready), W'(3'b100));
        next();
        check_wb("rr_w7", 1'b1, RF_WRITE, 5'd7, 64'hC);
        req_valid = 3'b000;
        #1;
        check("rr_none", W'(req_ready), W'(0));
        next();
        check_wb("rr_idle", 1'b0, RF_NOP, 5'd7, 64'hC);

        // Issue rd 9, then load unit commits it
        query_rd = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        check("busy9_nobypass", W'(rd_busy), W'(0));
        next();
        issue_valid = 1'b0;
        #1;
        check("busy9_set", W'(rd_busy), W'(1));
        set_req(1, 5'd9, 64'hDEAD);
        req_valid = 3'b010;
        #1;
        check("load_grant", W'(req_ready), W'(3'b010));
        next();
        req_valid = 3'b000;
        check_wb("load_w9", 1'b1, RF_WRITE, 5'd9, 64'hDEAD);
        check("busy9_held", W'(rd_busy), W'(1));
        next();
        check("busy9_clr", W'(rd_busy), W'(0));
        check("load_idle", W'(write_back_enabled), W'(0));

        // Same-edge issue and commit of rd 4: set wins
        query_rd = 5'd4;
        issue(5'd4);
        check("busy4_set", W'(rd_busy), W'(1));
        set_req(0, 5'd4, 64'h44);
        req_valid = 3'b001;
        #1;
        check("alu_grant4", W'(req_ready), W'(3'b001));
        next();
        req_valid = 3'b000;
        check_wb("alu_w4", 1'b1, RF_WRITE, 5'd4, 64'h44);
        issue(5'd4);
        check("busy4_setwins", W'(rd_busy), W'(1));

        // Write to rd 0 is dropped but advances the pointer
        set_req(1, 5'd0, 64'h99);
        req_valid = 3'b010;
        #1;
        check("rd0_grant", W'(req_ready), W'(3'b010));
        next();
        req_valid = 3'b000;
        check_wb("rd0_drop", 1'b0, RF_NOP, 5'd4, 64'h44);
        set_req(0, 5'd12, 64'h12);
        set_req(1, 5'd13, 64'h13);
        set_req(2, 5'd14, 64'hE);
        req_valid = 3'b111;
        #1;
        check("rd0_next", W'(req_ready), W'(3'b100));
        next();
        req_valid = 3'b000;
        check_wb("w14", 1'b1, RF_WRITE, 5'd14, 64'hE);
        next();

        // Freeze with rdy_in low while a write is presented
        query_rd = 5'd3;
        query_rs2 = 5'd21;
        issue(5'd3);
        set_req(0, 5'd3, 64'h33);
        req_valid = 3'b001;
        #1;
        check("frz_grant", W'(req_ready), W'(3'b001));
        next();
        check_wb("frz_w3", 1'b1, RF_WRITE, 5'd3, 64'h33);
        rdy_in = 1'b0;
        set_req(1, 5'd20, 64'h20);
        req_valid = 3'b010;
        issue_valid = 1'b1; issue_rd = 5'd21;
        #1;
        check("frz_noready", W'(req_ready), W'(0));
        for (int c = 0; c < 3; c++) begin
            next();
            check_wb("frz_hold", 1'b1, RF_WRITE, 5'd3, 64'h33);
            check("frz_busy3", W'(rd_busy), W'(1));
            check("frz_busy21", W'(rs2_busy), W'(0));
            check("frz_ready", W'(req_ready), W'(0));
        end
        rdy_in = 1'b1;
        issue_valid = 1'b0;
        #1;
        check("thaw_grant", W'(req_ready), W'(3'b010));
        next();
        req_valid = 3'b000;
        check("thaw_busy3", W'(rd_busy), W'(0));
        check_wb("thaw_w20", 1'b1, RF_WRITE, 5'd20, 64'h20);
        next();
        check("thaw_idle", W'(write_back_enabled), W'(0));

        // Reset mid-operation
        issue(5'd8);
        issue(5'd9);
        issue(5'd10);
        issue(5'd11);
        query_rs1 = 5'd8; query_rs2 = 5'd11; query_rd = 5'd10;
        #1;
        check("pre_busy8", W'(rs1_busy), W'(1));
        check("pre_busy11", W'(rs2_busy), W'(1));
        check("pre_busy10", W'(rd_busy), W'(1));
        set_req(2, 5'd15, 64'hF);
        req_valid = 3'b100;
        #1;
        check("pre_grant", W'(req_ready), W'(3'b100));
        next();
        req_valid = 3'b000;
        check_wb("pre_w15", 1'b1, RF_WRITE, 5'd15, 64'hF);
        rst = 1'b0;
        req_valid = 3'b111;
        #1;
        check("rst_noready", W'(req_ready), W'(0));
        next();
        rst = 1'b1;
        #1;
        check_wb("rst_idle", 1'b0, RF_NOP, 5'd0, '0);
        check("rst_busy8", W'(rs1_busy), W'(0));
        check("rst_busy11", W'(rs2_busy), W'(0));
        check("rst_busy10", W'(rd_busy), W'(0));
        query_rd = 5'd4;
        #1;
        check("rst_busy4", W'(rd_busy), W'(0));
        check("rst_grant0", W'(req_ready), W'(3'b001));
        req_valid = 3'b000;
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
